// File: rtl/mem_ctrl.sv
// Load/store controller: serialises 32-bit MEM-stage accesses into little-endian byte
// accesses on an 8-bit single-port RAM, with zero/sign extension of load results.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        memReq_in,
  input  logic        memWr_in,
  input  logic [31:0] memAddr_in,
  input  logic [31:0] memData_in,
  input  logic [1:0]  memWidth_in,
  input  logic        memSignExt_in,
  output logic        memDone_out,
  output logic [31:0] memData_out,
  output logic        memBusy_out,
  output logic [31:0] ram_addr_out,
  output logic        ram_wr_out,
  output logic [7:0]  ram_data_out,
  input  logic [7:0]  ram_data_in
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic        sign_q, sign_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] result_q, result_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    nbytes_d = nbytes_q;
    sign_d   = sign_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (memReq_in) begin
          addr_d   = memAddr_in;
          data_d   = memData_in;
          sign_d   = memSignExt_in;
          idx_d    = 3'd0;
          result_d = 32'd0;
          case (memWidth_in)
            2'd0:    nbytes_d = 3'd1;
            2'd1:    nbytes_d = 3'd2;
            default: nbytes_d = 3'd4;
          endcase
          state_d = memWr_in ? StWrite : StRead;
        end
      end
      StWrite: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == nbytes_q - 3'd1) state_d = StDone;
      end
      StRead: begin
        // RAM data lags its address by one cycle, so capture lands one index behind.
        case (idx_q)
          3'd1:    result_d[7:0]   = ram_data_in;
          3'd2:    result_d[15:8]  = ram_data_in;
          3'd3:    result_d[23:16] = ram_data_in;
          3'd4:    result_d[31:24] = ram_data_in;
          default: ;
        endcase
        idx_d = idx_q + 3'd1;
        if (idx_q == nbytes_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      nbytes_q <= 3'd0;
      sign_q   <= 1'b0;
      idx_q    <= 3'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      nbytes_q <= nbytes_d;
      sign_q   <= sign_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  logic        issue, writing;
  logic [31:0] cur_addr, ext;
  logic [7:0]  cur_byte;

  always_comb begin
    // Outputs are forced low while reset is high so an aborted store writes nothing more.
    writing  = !rst_in && (state_q == StWrite);
    issue    = !rst_in && (state_q == StRead) && (idx_q != nbytes_q);
    cur_addr = addr_q + 32'(idx_q);
    case (idx_q[1:0])
      2'd0:    cur_byte = data_q[7:0];
      2'd1:    cur_byte = data_q[15:8];
      2'd2:    cur_byte = data_q[23:16];
      default: cur_byte = data_q[31:24];
    endcase
    case (nbytes_q)
      3'd1:    ext = {{24{sign_q & result_q[7]}}, result_q[7:0]};
      3'd2:    ext = {{16{sign_q & result_q[15]}}, result_q[15:0]};
      default: ext = result_q;
    endcase
    ram_addr_out = (writing || issue) ? cur_addr : 32'd0;
    ram_wr_out   = writing;
    ram_data_out = writing ? cur_byte : 8'd0;
    memDone_out  = !rst_in && (state_q == StDone);
    memData_out  = memDone_out ? ext : 32'd0;
    memBusy_out  = !rst_in && (state_q != StIdle);
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr, sext;
  logic [31:0] addr, wdata;
  logic [1:0]  width;
  logic        done, busy, ram_wr;
  logic [31:0] rdata, ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'd0;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  int done_count = 0;

  logic [7:0] mem [0:4095];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .memReq_in     (req),
    .memWr_in      (wr),
    .memAddr_in    (addr),
    .memData_in    (wdata),
    .memWidth_in   (width),
    .memSignExt_in (sext),
    .memDone_out   (done),
    .memData_out   (rdata),
    .memBusy_out   (busy),
    .ram_addr_out  (ram_addr),
    .ram_wr_out    (ram_wr),
    .ram_data_out  (ram_wdata),
    .ram_data_in   (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_wr) begin
      mem[ram_addr[11:0]] <= ram_wdata;
      wr_count <= wr_count + 1;
    end
    if (done) done_count <= done_count + 1;
    ram_rdata <= mem[ram_addr[11:0]];
  end

  // Load vectors: address, width code, sign flag, byte count, expected result.
  logic [31:0] ld_addr [7] = '{32'h100, 32'h7, 32'h7, 32'h201, 32'hFFFF_FFFF, 32'h100, 32'h101};
  logic [1:0]  ld_w    [7] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd1};
  logic        ld_s    [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int          ld_n    [7] = '{4, 1, 1, 2, 2, 4, 2};
  logic [31:0] ld_exp  [7] = '{32'h4433_2211, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_FFFE,
                               32'hFFFF_9234, 32'h4433_2211, 32'h0000_3322};

  logic [31:0] st_addr [3] = '{32'h300, 32'h310, 32'h3FF};
  logic [31:0] st_data [3] = '{32'hDEAD_BEEF, 32'h1234_56A5, 32'h5555_1234};
  logic [1:0]  st_w    [3] = '{2'd2, 2'd0, 2'd1};
  int          st_n    [3] = '{4, 1, 2};

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; wr = 1'b1; addr = 32'h55; wdata = 32'hFFFF_FFFF;
    width = 2'd2; sext = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || rdata !== 32'd0 || busy !== 1'b0 || ram_addr !== 32'd0 ||
        ram_wr !== 1'b0 || ram_wdata !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: done=%b data=%h busy=%b raddr=%h rwr=%b rdat=%h, want all 0",
               done, rdata, busy, ram_addr, ram_wr, ram_wdata);
    end
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ram_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: busy=%b rwr=%b, want 0 0", busy, ram_wr);
    end
  endtask

  task automatic run_load(input int i);
    logic [31:0] a, exp;
    int n;
    a = ld_addr[i];
    n = ld_n[i];
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = a; width = ld_w[i]; sext = ld_s[i]; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    addr = 32'h0BAD_0BAD; width = 2'd0; sext = ~ld_s[i];
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      exp = (c < n) ? a + 32'(c) : 32'd0;
      vectors++;
      if (ram_addr !== exp || ram_wr !== 1'b0 || busy !== 1'b1 || done !== 1'b0 ||
          rdata !== 32'd0) begin
        miscompares++;
        $display("FAIL load%0d_cycle%0d: raddr=%h rwr=%b busy=%b done=%b data=%h, want raddr=%h 0 1 0 0",
                 i, c, ram_addr, ram_wr, busy, done, rdata, exp);
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || rdata !== ld_exp[i] || busy !== 1'b1 || ram_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL load%0d_done: done=%b data=%h busy=%b raddr=%h, want 1 %h 1 0",
               i, done, rdata, busy, ram_addr, ld_exp[i]);
    end
    req = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL load%0d_idle: busy=%b done=%b data=%h, want 0 0 0", i, busy, done, rdata);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < 7; i++) run_load(i);
  endtask

  task automatic test_store();
    logic [31:0] a, exp_a;
    logic [7:0]  exp_b;
    int n, w0;
    for (int i = 0; i < 3; i++) begin
      a = st_addr[i];
      n = st_n[i];
      w0 = wr_count;
      @(negedge clk);
      req = 1'b1; wr = 1'b1; addr = a; wdata = st_data[i]; width = st_w[i]; sext = 1'b0;
      @(posedge clk);
      #1;
      addr = 32'hFFFF_0000; wdata = 32'h0; width = 2'd2;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        exp_a = a + 32'(c);
        exp_b = 8'((st_data[i] >> (8 * c)) & 32'hFF);
        vectors++;
        if (ram_addr !== exp_a || ram_wdata !== exp_b || ram_wr !== 1'b1 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL store%0d_byte%0d: raddr=%h rdat=%h rwr=%b done=%b, want %h %h 1 0",
                   i, c, ram_addr, ram_wdata, ram_wr, done, exp_a, exp_b);
        end
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || ram_wr !== 1'b0 || rdata !== 32'd0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL store%0d_done: done=%b rwr=%b data=%h busy=%b, want 1 0 0 1",
                 i, done, ram_wr, rdata, busy);
      end
      req = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || wr_count - w0 != n) begin
        miscompares++;
        $display("FAIL store%0d_idle: busy=%b writes=%0d, want 0 %0d", i, busy, wr_count - w0, n);
      end
      for (int c = 0; c < n; c++) begin
        exp_a = a + 32'(c);
        exp_b = 8'((st_data[i] >> (8 * c)) & 32'hFF);
        vectors++;
        if (mem[exp_a[11:0]] !== exp_b) begin
          miscompares++;
          $display("FAIL store%0d_mem%0d: got %h want %h", i, c, mem[exp_a[11:0]], exp_b);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_count;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 32'h7; width = 2'd0; sext = 1'b0;
    @(posedge clk);
    repeat (2) @(negedge clk);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || rdata !== 32'h80) begin
      miscompares++;
      $display("FAIL b2b_load_done: done=%b data=%h, want 1 00000080", done, rdata);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done_count - d0 != 1) begin
      miscompares++;
      $display("FAIL b2b_no_reaccept: busy=%b dones=%0d, want 0 1", busy, done_count - d0);
    end
    wr = 1'b1; addr = 32'h320; wdata = 32'hAAAA_AA5A; width = 2'd0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || ram_wr !== 1'b1 || ram_addr !== 32'h320 || ram_wdata !== 8'h5A) begin
      miscompares++;
      $display("FAIL b2b_store: busy=%b rwr=%b raddr=%h rdat=%h, want 1 1 00000320 5a",
               busy, ram_wr, ram_addr, ram_wdata);
    end
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem[12'h320] !== 8'h5A || busy !== 1'b0 || done_count - d0 != 2) begin
      miscompares++;
      $display("FAIL b2b_end: mem=%h busy=%b dones=%0d, want 5a 0 2",
               mem[12'h320], busy, done_count - d0);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    w0 = wr_count;
    d0 = done_count;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h340; wdata = 32'h0403_0201; width = 2'd2;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (ram_wr !== 1'b0 || ram_addr !== 32'd0 || ram_wdata !== 8'd0 || busy !== 1'b0 ||
        done !== 1'b0 || rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: rwr=%b raddr=%h rdat=%h busy=%b done=%b data=%h, want all 0",
               ram_wr, ram_addr, ram_wdata, busy, done, rdata);
    end
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (wr_count - w0 != 2 || done_count != d0 || mem[12'h340] !== 8'h01 ||
        mem[12'h341] !== 8'h02 || mem[12'h342] !== 8'h00 || mem[12'h343] !== 8'h00 ||
        busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_state: writes=%0d dones=%0d mem=%h %h %h %h busy=%b, want 2 0 01 02 00 00 0",
               wr_count - w0, done_count - d0, mem[12'h340], mem[12'h341], mem[12'h342],
               mem[12'h343], busy);
    end
    run_load(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    mem[12'h007] = 8'h80;
    mem[12'h201] = 8'hFE; mem[12'h202] = 8'hFF;
    mem[12'hFFF] = 8'h34; mem[12'h000] = 8'h92;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
